// File: rtl/accu_pkg.sv
// Shared definitions for the PLC accumulator stack: opcode encoding and default sizing.
package accu_pkg;

    localparam int unsigned ACCU_DATA_W_DEF = 8;
    localparam int unsigned ACCU_DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        ACCU_OP_LDA  = 3'b000,
        ACCU_OP_LDM  = 3'b001,
        ACCU_OP_LDR  = 3'b010,
        ACCU_OP_LDU  = 3'b011,
        ACCU_OP_PUSH = 3'b100,
        ACCU_OP_POP  = 3'b101,
        ACCU_OP_SWAP = 3'b110,
        ACCU_OP_CLR  = 3'b111
    } accu_op_e;

endpackage

// File: rtl/accu_src_mux.sv
// Load-source selection for the top accumulator entry, driven by opcode bits [1:0].
module accu_src_mux
    import accu_pkg::*;
#(
    parameter int unsigned DATA_W = ACCU_DATA_W_DEF
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] arg_i,
    input  logic [DATA_W-1:0] ram_i,
    input  logic [DATA_W-1:0] reg_i,
    input  logic [DATA_W-1:0] alu_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = arg_i;
        unique case (sel_i)
            2'b00: data_o = arg_i;
            2'b01: data_o = ram_i;
            2'b10: data_o = reg_i;
            2'b11: data_o = alu_i;
            default: data_o = arg_i;
        endcase
    end

endmodule

// File: rtl/accu_stack.sv
// Push-down accumulator stack with occupancy count; sticky overflow/underflow
// flags are compiled in only when ACCU_STACK_ERR_EN is defined.
module accu_stack
    import accu_pkg::*;
#(
    parameter int unsigned DATA_W = ACCU_DATA_W_DEF,
    parameter int unsigned DEPTH  = ACCU_DEPTH_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ACCU_WE,
    input  logic [2:0]                 ACCU_OPCode,
    input  logic [DATA_W-1:0]          ACCU_ArgToSet,
    input  logic [DATA_W-1:0]          ACCU_RAMData,
    input  logic [DATA_W-1:0]          ACCU_Register,
    input  logic [DATA_W-1:0]          ACCU_ALU_Result,
    output logic [DATA_W-1:0]          ACCU_Top,
    output logic [DATA_W-1:0]          ACCU_Next,
    output logic [$clog2(DEPTH+1)-1:0] ACCU_Depth,
    output logic                       ACCU_Zero,
    output logic                       ACCU_Overflow,
    output logic                       ACCU_Underflow
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    accu_op_e          op;
    logic [DATA_W-1:0] src_data;
    logic [DATA_W-1:0] e_q [DEPTH];
    logic [DATA_W-1:0] e_d [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;

    assign op = accu_op_e'(ACCU_OPCode);

    accu_src_mux #(
        .DATA_W (DATA_W)
    ) u_src_mux (
        .sel_i  (ACCU_OPCode[1:0]),
        .arg_i  (ACCU_ArgToSet),
        .ram_i  (ACCU_RAMData),
        .reg_i  (ACCU_Register),
        .alu_i  (ACCU_ALU_Result),
        .data_o (src_data)
    );

`ifdef ACCU_STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
`endif

    always_comb begin
        e_d     = e_q;
        depth_d = depth_q;
`ifdef ACCU_STACK_ERR_EN
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`endif
        if (ACCU_WE) begin
            unique case (op)
                ACCU_OP_LDA, ACCU_OP_LDM, ACCU_OP_LDR, ACCU_OP_LDU: begin
                    e_d[0] = src_data;
                    if (depth_q == '0) depth_d = DW'(1);
                end
                ACCU_OP_PUSH: begin
                    for (int unsigned i = 1; i < DEPTH; i++) e_d[i] = e_q[i-1];
                    if (depth_q == DEPTH_FULL) begin
`ifdef ACCU_STACK_ERR_EN
                        ovf_d = 1'b1;
`endif
                    end else begin
                        depth_d = depth_q + DW'(1);
                    end
                end
                ACCU_OP_POP: begin
                    // Shift happens even when empty so data behaviour is build-independent.
                    for (int unsigned i = 0; i < DEPTH - 1; i++) e_d[i] = e_q[i+1];
                    e_d[DEPTH-1] = '0;
                    if (depth_q == '0) begin
`ifdef ACCU_STACK_ERR_EN
                        unf_d = 1'b1;
`endif
                    end else begin
                        depth_d = depth_q - DW'(1);
                    end
                end
                ACCU_OP_SWAP: begin
                    e_d[0] = e_q[1];
                    e_d[1] = e_q[0];
                end
                ACCU_OP_CLR: begin
                    for (int unsigned i = 0; i < DEPTH; i++) e_d[i] = '0;
                    depth_d = '0;
`ifdef ACCU_STACK_ERR_EN
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) e_q[i] <= '0;
            depth_q <= '0;
        end else begin
            e_q     <= e_d;
            depth_q <= depth_d;
        end
    end

`ifdef ACCU_STACK_ERR_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ACCU_Overflow  = ovf_q;
    assign ACCU_Underflow = unf_q;
`else
    assign ACCU_Overflow  = 1'b0;
    assign ACCU_Underflow = 1'b0;
`endif

    assign ACCU_Top   = e_q[0];
    assign ACCU_Next  = e_q[1];
    assign ACCU_Depth = depth_q;
    assign ACCU_Zero  = (e_q[0] == '0);

endmodule

// File: tb/tb_accu_stack.sv
// Self-checking bench for accu_stack: directed vector table, hand-written
// overflow/reset sequences, and randomized ops against a queue-based model.
module tb_accu_stack;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DW     = $clog2(DEPTH + 1);
`ifdef ACCU_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              ACCU_WE = 1'b0;
    logic [2:0]        ACCU_OPCode = '0;
    logic [DATA_W-1:0] ACCU_ArgToSet = '0, ACCU_RAMData = '0;
    logic [DATA_W-1:0] ACCU_Register = '0, ACCU_ALU_Result = '0;
    logic [DATA_W-1:0] ACCU_Top, ACCU_Next;
    logic [DW-1:0]     ACCU_Depth;
    logic              ACCU_Zero, ACCU_Overflow, ACCU_Underflow;

    accu_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ACCU_WE         (ACCU_WE),
        .ACCU_OPCode     (ACCU_OPCode),
        .ACCU_ArgToSet   (ACCU_ArgToSet),
        .ACCU_RAMData    (ACCU_RAMData),
        .ACCU_Register   (ACCU_Register),
        .ACCU_ALU_Result (ACCU_ALU_Result),
        .ACCU_Top        (ACCU_Top),
        .ACCU_Next       (ACCU_Next),
        .ACCU_Depth      (ACCU_Depth),
        .ACCU_Zero       (ACCU_Zero),
        .ACCU_Overflow   (ACCU_Overflow),
        .ACCU_Underflow  (ACCU_Underflow)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: the stack as a queue of DEPTH values, front = top.
    int unsigned mq[$];
    int unsigned mdepth;
    bit          movf, munf;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < int'(DEPTH); i++) mq.push_back(0);
        mdepth = 0;
        movf   = 0;
        munf   = 0;
    endfunction

    function automatic void model_op(input bit rst, input bit we, input int unsigned op,
                                     input int unsigned arg, input int unsigned ram,
                                     input int unsigned rg, input int unsigned alu);
        int unsigned tmp;
        if (rst) begin
            model_reset();
            return;
        end
        if (!we) return;
        case (op)
            0, 1, 2, 3: begin
                mq[0]  = (op == 0) ? arg : (op == 1) ? ram : (op == 2) ? rg : alu;
                mdepth = (mdepth == 0) ? 1 : mdepth;
            end
            4: begin
                mq.push_front(mq[0]);
                void'(mq.pop_back());
                if (mdepth == DEPTH) movf = ERR;
                else mdepth = mdepth + 1;
            end
            5: begin
                void'(mq.pop_front());
                mq.push_back(0);
                if (mdepth == 0) munf = ERR;
                else mdepth = mdepth - 1;
            end
            6: begin
                tmp = mq[0]; mq[0] = mq[1]; mq[1] = tmp;
            end
            default: begin
                model_reset();
            end
        endcase
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " top"},   ACCU_Top,       mq[0]);
        chk({tag, " next"},  ACCU_Next,      mq[1]);
        chk({tag, " depth"}, ACCU_Depth,     mdepth);
        chk({tag, " zero"},  ACCU_Zero,      (mq[0] == 0) ? 1 : 0);
        chk({tag, " ovf"},   ACCU_Overflow,  movf);
        chk({tag, " unf"},   ACCU_Underflow, munf);
    endtask

    // Drive one cycle; unselected sources carry junk so only the chosen one may land.
    task automatic step(input bit rst, input bit we, input logic [2:0] op,
                        input logic [DATA_W-1:0] d);
        RST             = rst;
        ACCU_WE         = we;
        ACCU_OPCode     = op;
        ACCU_ArgToSet   = DATA_W'($urandom);
        ACCU_RAMData    = DATA_W'($urandom);
        ACCU_Register   = DATA_W'($urandom);
        ACCU_ALU_Result = DATA_W'($urandom);
        case (op[1:0])
            2'd0: ACCU_ArgToSet   = d;
            2'd1: ACCU_RAMData    = d;
            2'd2: ACCU_Register   = d;
            default: ACCU_ALU_Result = d;
        endcase
        @(posedge CLK);
        model_op(rst, we, op, ACCU_ArgToSet, ACCU_RAMData, ACCU_Register, ACCU_ALU_Result);
        #1;
        RST     = 1'b0;
        ACCU_WE = 1'b0;
    endtask

    typedef struct {
        bit               we;
        logic [2:0]       op;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] nxt;
        int unsigned      depth;
        bit               ovf;
        bit               unf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1, 3'd0, 8'h5A, 8'h5A, 8'h00, 1, 0, 0});
        tbl.push_back('{1, 3'd0, 8'h11, 8'h11, 8'h00, 1, 0, 0});
        tbl.push_back('{1, 3'd4, 8'h00, 8'h11, 8'h11, 2, 0, 0});
        tbl.push_back('{1, 3'd1, 8'h22, 8'h22, 8'h11, 2, 0, 0});
        tbl.push_back('{1, 3'd4, 8'h00, 8'h22, 8'h22, 3, 0, 0});
        tbl.push_back('{1, 3'd2, 8'h33, 8'h33, 8'h22, 3, 0, 0});
        tbl.push_back('{1, 3'd6, 8'h00, 8'h22, 8'h33, 3, 0, 0});
        tbl.push_back('{1, 3'd5, 8'h00, 8'h33, 8'h11, 2, 0, 0});
        tbl.push_back('{1, 3'd5, 8'h00, 8'h11, 8'h00, 1, 0, 0});
        tbl.push_back('{1, 3'd5, 8'h00, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 3'd5, 8'h00, 8'h00, 8'h00, 0, 0, ERR});
        tbl.push_back('{0, 3'd3, 8'h80, 8'h00, 8'h00, 0, 0, ERR});
        tbl.push_back('{1, 3'd3, 8'h80, 8'h80, 8'h00, 1, 0, ERR});
        tbl.push_back('{1, 3'd7, 8'h00, 8'h00, 8'h00, 0, 0, 0});

        model_reset();
        @(negedge CLK);
        step(1, 0, 3'd0, '0);
        chk("reset top",   ACCU_Top,       0);
        chk("reset next",  ACCU_Next,      0);
        chk("reset depth", ACCU_Depth,     0);
        chk("reset zero",  ACCU_Zero,      1);
        chk("reset ovf",   ACCU_Overflow,  0);
        chk("reset unf",   ACCU_Underflow, 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].we, tbl[i].op, tbl[i].d);
            chk($sformatf("vec%0d top", i),   ACCU_Top,       tbl[i].top);
            chk($sformatf("vec%0d next", i),  ACCU_Next,      tbl[i].nxt);
            chk($sformatf("vec%0d depth", i), ACCU_Depth,     tbl[i].depth);
            chk($sformatf("vec%0d zero", i),  ACCU_Zero,      (tbl[i].top == 0) ? 1 : 0);
            chk($sformatf("vec%0d ovf", i),   ACCU_Overflow,  tbl[i].ovf);
            chk($sformatf("vec%0d unf", i),   ACCU_Underflow, tbl[i].unf);
        end

        // Overflow: load 0x01 then five pushes saturate depth at DEPTH.
        step(0, 1, 3'd0, 8'h01);
        for (int i = 0; i < 5; i++) step(0, 1, 3'd4, '0);
        chk("ovf depth", ACCU_Depth,    DEPTH);
        chk("ovf flag",  ACCU_Overflow, ERR);
        chk("ovf top",   ACCU_Top,      8'h01);
        for (int i = 0; i < 3; i++) step(0, 1, 3'd5, '0);
        chk("ovf e3 via pops", ACCU_Top,   8'h01);
        chk("ovf e3 depth",    ACCU_Depth, 1);
        chk("ovf flag held",   ACCU_Overflow, ERR);
        step(0, 1, 3'd7, '0);
        chk("clr top",   ACCU_Top,       0);
        chk("clr next",  ACCU_Next,      0);
        chk("clr depth", ACCU_Depth,     0);
        chk("clr zero",  ACCU_Zero,      1);
        chk("clr ovf",   ACCU_Overflow,  0);
        chk("clr unf",   ACCU_Underflow, 0);

        // Reset beats a concurrent operation.
        step(0, 1, 3'd0, 8'h44);
        step(0, 1, 3'd4, '0);
        step(1, 1, 3'd3, 8'h80);
        chk("rst+op top",   ACCU_Top,   0);
        chk("rst+op next",  ACCU_Next,  0);
        chk("rst+op depth", ACCU_Depth, 0);
        chk("rst+op zero",  ACCU_Zero,  1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0) ? '0 : DATA_W'($urandom));
            chk_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
